// File: rtl/tap_ctrl_if.sv
// Scan-chain bus between the TAP controller (master) and the boundary-scan cell chain (slave).
interface tap_ctrl_if;
    logic bsr_si;
    logic bsr_so;
    logic bsr_shift;
    logic bsr_capture;
    logic bsr_update;
    logic bsr_en;

    modport master (
        output bsr_si, bsr_shift, bsr_capture, bsr_update, bsr_en,
        input  bsr_so
    );

    modport slave (
        input  bsr_si, bsr_shift, bsr_capture, bsr_update, bsr_en,
        output bsr_so
    );
endinterface

// File: rtl/tap_ctrl.sv
// IEEE 1149.1-style TAP controller on the system clock, driving a boundary-scan chain.
// Define TAP_IDCODE_EN to add the 32-bit IDCODE register and make IDCODE the reset instruction.
module tap_ctrl #(
    parameter int          IR_W       = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic            clock,
    input  logic            rst_l,
    input  logic            tms,
    input  logic            tdi,
    output logic            tdo,
    output logic            tdo_en,
    tap_ctrl_if.master      bsr,
    output logic [IR_W-1:0] ir,
    output logic [3:0]      tap_state
);

    typedef enum logic [3:0] {
        EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3,
        SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
        EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB,
        RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
    } state_t;

    localparam logic [IR_W-1:0] EXTEST = '0;
    localparam logic [IR_W-1:0] SAMPLE = IR_W'(1);
`ifdef TAP_IDCODE_EN
    localparam logic [IR_W-1:0] IDCODE = IR_W'(2);
    localparam logic [IR_W-1:0] IR_RST = IDCODE;
`else
    localparam logic [IR_W-1:0] IR_RST = '1;
`endif

    if (IR_W < 2) begin : g_bad_ir_w
        $error("tap_ctrl: IR_W must be at least 2");
    end
    if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
        $error("tap_ctrl: IDCODE_VAL LSB must be 1");
    end

    state_t          state;
    state_t          next_state;
    logic [IR_W-1:0] ir_sr;
    logic            bypass;
    logic            bsr_sel;
    logic            dr_lsb;

    always_ff @(posedge clock) begin
        if (!rst_l) begin
            state  <= TLR;
            ir     <= IR_RST;
            ir_sr  <= '0;
            bypass <= 1'b0;
        end else begin
            state <= next_state;

            case (state)
                CAP_IR:  ir_sr <= IR_W'(1);
                SH_IR:   ir_sr <= {tdi, ir_sr[IR_W-1:1]};
                default: ;
            endcase

            // ir is reloaded on the edge that enters TLR, not one cycle later
            if (next_state == TLR)
                ir <= IR_RST;
            else if (state == UPD_IR)
                ir <= ir_sr;

            if (state == CAP_DR)
                bypass <= 1'b0;
            else if (state == SH_DR)
                bypass <= tdi;
        end
    end

`ifdef TAP_IDCODE_EN
    logic [31:0] id_sr;
    logic        id_sel;

    assign id_sel = (ir == IDCODE);

    always_ff @(posedge clock) begin
        if (!rst_l)
            id_sr <= '0;
        else if (id_sel && state == CAP_DR)
            id_sr <= IDCODE_VAL;
        else if (id_sel && state == SH_DR)
            id_sr <= {tdi, id_sr[31:1]};
    end

    assign dr_lsb = id_sel ? id_sr[0] : bypass;
`else
    assign dr_lsb = bypass;
`endif

    always_comb begin
        next_state = state;
        case (state)
            TLR:     next_state = tms ? TLR    : RTI;
            RTI:     next_state = tms ? SEL_DR : RTI;
            SEL_DR:  next_state = tms ? SEL_IR : CAP_DR;
            CAP_DR:  next_state = tms ? EX1_DR : SH_DR;
            SH_DR:   next_state = tms ? EX1_DR : SH_DR;
            EX1_DR:  next_state = tms ? UPD_DR : PAU_DR;
            PAU_DR:  next_state = tms ? EX2_DR : PAU_DR;
            EX2_DR:  next_state = tms ? UPD_DR : SH_DR;
            UPD_DR:  next_state = tms ? SEL_DR : RTI;
            SEL_IR:  next_state = tms ? TLR    : CAP_IR;
            CAP_IR:  next_state = tms ? EX1_IR : SH_IR;
            SH_IR:   next_state = tms ? EX1_IR : SH_IR;
            EX1_IR:  next_state = tms ? UPD_IR : PAU_IR;
            PAU_IR:  next_state = tms ? EX2_IR : PAU_IR;
            EX2_IR:  next_state = tms ? UPD_IR : SH_IR;
            UPD_IR:  next_state = tms ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
    end

    // Serial output is combinational so the first bit shows in the cycle the shift state is entered
    always_comb begin
        tdo = 1'b0;
        case (state)
            SH_IR:   tdo = ir_sr[0];
            SH_DR:   tdo = bsr_sel ? bsr.bsr_so : dr_lsb;
            default: ;
        endcase
    end

    assign bsr_sel         = (ir == EXTEST) || (ir == SAMPLE);
    assign tdo_en          = (state == SH_DR) || (state == SH_IR);
    assign tap_state       = state;
    assign bsr.bsr_si      = tdi;
    assign bsr.bsr_capture = bsr_sel && (state == CAP_DR || state == SH_DR);
    assign bsr.bsr_shift   = bsr_sel && (state == SH_DR);
    assign bsr.bsr_update  = bsr_sel && (state == UPD_DR);
    assign bsr.bsr_en      = (ir == EXTEST);

endmodule

// File: tb/tb_tap_ctrl.sv
// Table-driven bench for tap_ctrl: each vector's expectations go through a scoreboard queue.
module tb_tap_ctrl;

    localparam int IR_W = 4;

    localparam logic [3:0] EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3;
    localparam logic [3:0] SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7;
    localparam logic [3:0] EX1_IR = 4'h9, SH_IR  = 4'hA;
    localparam logic [3:0] RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF;
`ifdef TAP_IDCODE_EN
    localparam logic [3:0] IRR = 4'h2;
`else
    localparam logic [3:0] IRR = 4'hF;
`endif

    // in = {rst_l, tms, tdi, bsr_so}; fl = {tdo_en, capture, shift, update, en}
    typedef struct {
        logic [3:0] in;
        logic [3:0] st;
        logic [3:0] ir;
        logic       tdo;
        logic [4:0] fl;
    } vec_t;

    logic            clock = 1'b0;
    logic            rst_l;
    logic            tms;
    logic            tdi;
    logic            tdo;
    logic            tdo_en;
    logic [IR_W-1:0] ir;
    logic [3:0]      tap_state;

    vec_t tbl[$];
    vec_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    tap_ctrl_if bsr_bus ();

    tap_ctrl #(.IR_W(IR_W), .IDCODE_VAL(32'h1000_0001)) dut (
        .clock     (clock),
        .rst_l     (rst_l),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tdo_en    (tdo_en),
        .bsr       (bsr_bus.master),
        .ir        (ir),
        .tap_state (tap_state)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [3:0] in, input logic [3:0] st,
                                input logic [3:0] irv, input logic o, input logic [4:0] fl);
        vec_t v;
        v.in  = in;
        v.st  = st;
        v.ir  = irv;
        v.tdo = o;
        v.fl  = fl;
        return v;
    endfunction

    function automatic void add(input logic [3:0] in, input logic [3:0] st,
                                input logic [3:0] irv, input logic o, input logic [4:0] fl);
        tbl.push_back(mk(in, st, irv, o, fl));
    endfunction

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL vec %0d %s: got %h, expected %h", vectors, nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL vec %0d %s: got %b, expected %b", vectors, nm, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        rst_l          = v.in[3];
        tms            = v.in[2];
        tdi            = v.in[1];
        bsr_bus.bsr_so = v.in[0];
        sb.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        @(posedge clock);
        #2;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL vec %0d scoreboard: got empty queue, expected an entry", vectors);
        end else begin
            e = sb.pop_front();
            chk4("tap_state",   tap_state,           e.st);
            chk4("ir",          ir,                  e.ir);
            chk1("tdo",         tdo,                 e.tdo);
            chk1("tdo_en",      tdo_en,              e.fl[4]);
            chk1("bsr_capture", bsr_bus.bsr_capture, e.fl[3]);
            chk1("bsr_shift",   bsr_bus.bsr_shift,   e.fl[2]);
            chk1("bsr_update",  bsr_bus.bsr_update,  e.fl[1]);
            chk1("bsr_en",      bsr_bus.bsr_en,      e.fl[0]);
            chk1("bsr_si",      bsr_bus.bsr_si,      e.in[1]);
        end
    endtask

    task automatic run(input vec_t v);
        applyStimulus(v);
        checkOutput();
    endtask

    initial begin
        logic [31:0] idv;
        idv            = 32'h1000_0001;
        rst_l          = 1'b0;
        tms            = 1'b0;
        tdi            = 1'b0;
        bsr_bus.bsr_so = 1'b0;

        // reset, rst_l beating tms=0
        add(4'b0000, TLR,    IRR,  1'b0, 5'b00000);
        add(4'b0010, TLR,    IRR,  1'b0, 5'b00000);
        add(4'b1000, RTI,    IRR,  1'b0, 5'b00000);
        // load EXTEST: shift 0000, tdo reads 1,0,0,0
        add(4'b1100, SEL_DR, IRR,  1'b0, 5'b00000);
        add(4'b1100, SEL_IR, IRR,  1'b0, 5'b00000);
        add(4'b1000, CAP_IR, IRR,  1'b0, 5'b00000);
        add(4'b1000, SH_IR,  IRR,  1'b1, 5'b10000);
        add(4'b1000, SH_IR,  IRR,  1'b0, 5'b10000);
        add(4'b1000, SH_IR,  IRR,  1'b0, 5'b10000);
        add(4'b1000, SH_IR,  IRR,  1'b0, 5'b10000);
        add(4'b1100, EX1_IR, IRR,  1'b0, 5'b00000);
        add(4'b1100, UPD_IR, IRR,  1'b0, 5'b00000);
        add(4'b1000, RTI,    4'h0, 1'b0, 5'b00001);
        // EXTEST DR scan through pause; bsr_en stays high
        add(4'b1100, SEL_DR, 4'h0, 1'b0, 5'b00001);
        add(4'b1000, CAP_DR, 4'h0, 1'b0, 5'b01001);
        add(4'b1011, SH_DR,  4'h0, 1'b1, 5'b11101);
        add(4'b1100, EX1_DR, 4'h0, 1'b0, 5'b00001);
        add(4'b1000, PAU_DR, 4'h0, 1'b0, 5'b00001);
        add(4'b1100, EX2_DR, 4'h0, 1'b0, 5'b00001);
        add(4'b1000, SH_DR,  4'h0, 1'b0, 5'b11101);
        add(4'b1100, EX1_DR, 4'h0, 1'b0, 5'b00001);
        add(4'b1100, UPD_DR, 4'h0, 1'b0, 5'b00011);
        add(4'b1000, RTI,    4'h0, 1'b0, 5'b00001);
        // load SAMPLE: tdi 1,0,0,0 LSB first
        add(4'b1100, SEL_DR, 4'h0, 1'b0, 5'b00001);
        add(4'b1100, SEL_IR, 4'h0, 1'b0, 5'b00001);
        add(4'b1000, CAP_IR, 4'h0, 1'b0, 5'b00001);
        add(4'b1000, SH_IR,  4'h0, 1'b1, 5'b10001);
        add(4'b1010, SH_IR,  4'h0, 1'b0, 5'b10001);
        add(4'b1000, SH_IR,  4'h0, 1'b0, 5'b10001);
        add(4'b1000, SH_IR,  4'h0, 1'b0, 5'b10001);
        add(4'b1100, EX1_IR, 4'h0, 1'b0, 5'b00001);
        add(4'b1100, UPD_IR, 4'h0, 1'b0, 5'b00001);
        add(4'b1000, RTI,    4'h1, 1'b0, 5'b00000);
        // SAMPLE BSR path: tdo mirrors bsr_so, single update pulse
        add(4'b1100, SEL_DR, 4'h1, 1'b0, 5'b00000);
        add(4'b1000, CAP_DR, 4'h1, 1'b0, 5'b01000);
        add(4'b1011, SH_DR,  4'h1, 1'b1, 5'b11100);
        add(4'b1000, SH_DR,  4'h1, 1'b0, 5'b11100);
        add(4'b1101, EX1_DR, 4'h1, 1'b0, 5'b00000);
        add(4'b1100, UPD_DR, 4'h1, 1'b0, 5'b00010);
        add(4'b1000, RTI,    4'h1, 1'b0, 5'b00000);
        // reset while in SH_DR with BSR selected: straight to TLR, no update
        add(4'b1100, SEL_DR, 4'h1, 1'b0, 5'b00000);
        add(4'b1000, CAP_DR, 4'h1, 1'b0, 5'b01000);
        add(4'b1001, SH_DR,  4'h1, 1'b1, 5'b11100);
        add(4'b0101, TLR,    IRR,  1'b0, 5'b00000);
        add(4'b1000, RTI,    IRR,  1'b0, 5'b00000);
        // load undecoded code 5: tdi 1,0,1,0
        add(4'b1100, SEL_DR, IRR,  1'b0, 5'b00000);
        add(4'b1100, SEL_IR, IRR,  1'b0, 5'b00000);
        add(4'b1000, CAP_IR, IRR,  1'b0, 5'b00000);
        add(4'b1000, SH_IR,  IRR,  1'b1, 5'b10000);
        add(4'b1010, SH_IR,  IRR,  1'b0, 5'b10000);
        add(4'b1000, SH_IR,  IRR,  1'b0, 5'b10000);
        add(4'b1010, SH_IR,  IRR,  1'b0, 5'b10000);
        add(4'b1100, EX1_IR, IRR,  1'b0, 5'b00000);
        add(4'b1100, UPD_IR, IRR,  1'b0, 5'b00000);
        add(4'b1000, RTI,    4'h5, 1'b0, 5'b00000);
        // bypass scan, bsr_so held high to expose a wrong DR select
        add(4'b1101, SEL_DR, 4'h5, 1'b0, 5'b00000);
        add(4'b1001, CAP_DR, 4'h5, 1'b0, 5'b00000);
        add(4'b1001, SH_DR,  4'h5, 1'b0, 5'b10000);
        add(4'b1011, SH_DR,  4'h5, 1'b1, 5'b10000);
        add(4'b1001, SH_DR,  4'h5, 1'b0, 5'b10000);
        add(4'b1011, SH_DR,  4'h5, 1'b1, 5'b10000);
        add(4'b1111, EX1_DR, 4'h5, 1'b0, 5'b00000);
        add(4'b1001, PAU_DR, 4'h5, 1'b0, 5'b00000);
        add(4'b1101, EX2_DR, 4'h5, 1'b0, 5'b00000);
        add(4'b1001, SH_DR,  4'h5, 1'b1, 5'b10000);

        for (int i = 0; i < tbl.size(); i++)
            run(tbl[i]);

        // five tms=1 cycles from SH_DR reach TLR and reload ir
        run(mk(4'b1100, EX1_DR, 4'h5, 1'b0, 5'b00000));
        run(mk(4'b1100, UPD_DR, 4'h5, 1'b0, 5'b00000));
        run(mk(4'b1100, SEL_DR, 4'h5, 1'b0, 5'b00000));
        run(mk(4'b1100, SEL_IR, 4'h5, 1'b0, 5'b00000));
        run(mk(4'b1100, TLR,    IRR,  1'b0, 5'b00000));
        run(mk(4'b1000, RTI,    IRR,  1'b0, 5'b00000));

        // reset in the middle of an IR shift: partial ir_sr is dropped
        run(mk(4'b1100, SEL_DR, IRR, 1'b0, 5'b00000));
        run(mk(4'b1100, SEL_IR, IRR, 1'b0, 5'b00000));
        run(mk(4'b1000, CAP_IR, IRR, 1'b0, 5'b00000));
        run(mk(4'b1000, SH_IR,  IRR, 1'b1, 5'b10000));
        run(mk(4'b1010, SH_IR,  IRR, 1'b0, 5'b10000));
        run(mk(4'b0110, TLR,    IRR, 1'b0, 5'b00000));
        run(mk(4'b1000, RTI,    IRR, 1'b0, 5'b00000));
        run(mk(4'b1000, RTI,    IRR, 1'b0, 5'b00000));

`ifdef TAP_IDCODE_EN
        // IDCODE scanned out LSB first straight after reset, then reset mid-shift
        run(mk(4'b0000, TLR,    IRR, 1'b0, 5'b00000));
        run(mk(4'b0000, TLR,    IRR, 1'b0, 5'b00000));
        run(mk(4'b1000, RTI,    IRR, 1'b0, 5'b00000));
        run(mk(4'b1100, SEL_DR, IRR, 1'b0, 5'b00000));
        run(mk(4'b1000, CAP_DR, IRR, 1'b0, 5'b00000));
        for (int k = 0; k < 32; k++)
            run(mk({3'b100, k[0]}, SH_DR, IRR, idv[k], 5'b10000));
        run(mk(4'b0000, TLR,    IRR, 1'b0, 5'b00000));
        run(mk(4'b1000, RTI,    IRR, 1'b0, 5'b00000));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tap_ctrl.md
Name: tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller running on the system clock.
- Decodes TMS/TDI into shift/capture/update/enable controls for the boundary-scan cell chain (bsr) and muxes the chain's serial output onto TDO.
- Holds the instruction register and the bypass register, plus an optional IDCODE register.
- Sits directly upstream of the BSR chain: drives the chain's shift/capture/update/en inputs and consumes its final scan_out.

Parameters:
- IR_W, 4: instruction register width (>=2).
- IDCODE_VAL, 32'h1000_0001: IDCODE contents; LSB must be 1. Used only with TAP_IDCODE_EN.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- rst_l  in  1  synchronous active-low reset.
- tms  in  1  test mode select.
- tdi  in  1  test data in.
- tdo  out  1  test data out.
- tdo_en  out  1  high while in SHIFT_DR or SHIFT_IR.
- bsr_si  out  1  scan input to the first BSR cell; equals tdi.
- bsr_so  in  1  scan_out of the last BSR cell.
- bsr_shift  out  1  BSR shift select.
- bsr_capture  out  1  BSR flop load enable.
- bsr_update  out  1  one-cycle update pulse.
- bsr_en  out  1  BSR drives pins (EXTEST active).
- ir  out  IR_W  current instruction.
- tap_state  out  4  current FSM state code.

Behaviour:
- Reset: rst_l=0 at a rising edge forces:
  - state=TLR, ir=IDCODE if enabled else BYPASS, ir_sr=0, bypass=0.
  - All outputs deasserted; tdo=0, tdo_en=0.
  - rst_l takes priority over every other input.
- State codes: TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAU_DR=3, EX2_DR=0, UPD_DR=5, SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAU_IR=B, EX2_IR=8, UPD_IR=D.
- Transitions (next state for tms=0 / tms=1):
  - TLR: RTI / TLR.
  - RTI: RTI / SEL_DR.
  - SEL_DR: CAP_DR / SEL_IR.
  - SEL_IR: CAP_IR / TLR.
  - CAP_x: SH_x / EX1_x.
  - SH_x: SH_x / EX1_x.
  - EX1_x: PAU_x / UPD_x.
  - PAU_x: PAU_x / EX2_x.
  - EX2_x: SH_x / UPD_x.
  - UPD_x: RTI / SEL_DR.
- Five consecutive tms=1 cycles reach TLR from any state. Entering TLR also loads ir with its reset value.
- Instructions:
  - EXTEST = 0.
  - SAMPLE = 1.
  - IDCODE = 2 (only with the macro).
  - BYPASS = all ones.
  - Any undecoded code behaves as BYPASS.
- IR path:
  - CAP_IR: ir_sr <= {0...,2'b01}.
  - SH_IR: ir_sr <= {tdi, ir_sr[IR_W-1:1]}.
  - UPD_IR: ir <= ir_sr.
  - ir changes only in UPD_IR or TLR.
- DR selection by ir: EXTEST/SAMPLE select BSR; IDCODE selects the ID register; otherwise bypass.
- Bypass register: CAP_DR loads 0; SH_DR loads tdi.
- BSR controls (combinational decode of state and ir):
  - bsr_capture = BSR selected & (state==CAP_DR | state==SH_DR).
  - bsr_shift = BSR selected & state==SH_DR.
  - bsr_update = BSR selected & state==UPD_DR; high exactly one cycle per UPD_DR visit.
  - bsr_en = (ir==EXTEST); does not change during DR scans.
- tdo:
  - In SH_IR: tdo = ir_sr[0].
  - In SH_DR: tdo = LSB of the selected DR (bsr_so, id_sr[0], or bypass).
  - Otherwise tdo = 0.
  - The first shifted bit is visible in the cycle the FSM enters the shift state.
- Pause, Exit1 and Exit2 states hold all registers.
- Mid-operation reset (rst_l low during SH_DR/SH_IR):
  - Next state is TLR.
  - Partial ir_sr contents are discarded; ir does not take them.
  - No bsr_update pulse is produced.

Optional Feature:
- Macro: TAP_IDCODE_EN.
- Defined:
  - Adds a 32-bit id_sr.
  - CAP_DR with IDCODE selected loads IDCODE_VAL.
  - SH_DR shifts right, with tdi entering at the MSB.
  - Reset/TLR instruction is IDCODE.
- Undefined:
  - No ID register.
  - Code 2 decodes as BYPASS.
  - Reset/TLR instruction is BYPASS.

Test Plan:
- Reset: rst_l=0 for 2 cycles -> tap_state=F, ir=4'hF (macro off), all bsr_* = 0, tdo_en=0. Then tms=0 -> tap_state=C.
- TLR recovery: from SH_DR, drive tms=1 for 5 cycles -> tap_state=F, ir at its reset value.
- IR load: shift IR_W=4 bits 0000 via SH_IR, then UPD_IR -> ir=0, bsr_en=1. Bits shifted out on tdo read 1,0,0,0.
- Bypass: ir=F, shift tdi=1,0,1,1 in SH_DR -> tdo=0,1,0,1 (one-cycle delay, leading capture 0).
- BSR path: ir=SAMPLE, pass through CAP_DR/SH_DR/UPD_DR -> bsr_capture high in CAP_DR and SH_DR only, bsr_shift high only in SH_DR, bsr_update high exactly 1 cycle, tdo mirrors bsr_so, bsr_en=0.
- IDCODE (macro on): after reset, scan 32 bits of DR -> tdo LSB-first equals 32'h1000_0001. Pulling rst_l low mid-shift -> TLR next cycle with no bsr_update.
